rgb_pwm_capture: RTL
====================

# rgb_pwm_capture

Three-channel PWM capture block: samples the RGB LED drive lines and measures high time and period of each channel in clock cycles. Used for on-board loopback self-test of the `rgbled_cycle` LED path and for reading back externally driven RGB PWM. Results from the three channels are serialized onto one valid/ready result port; per-channel overrun flags are sticky.

## Interface
- `CNT_W`, 20: width of the high-time and period counters and results.
- `TIMEOUT`, 20'hFFFFF: cycles without a rising edge before a channel reports stuck. Must be in the range 2 to 2^CNT_W-1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  capture enable. Low forces every channel FSM to IDLE.
- `rgb_in`  in  3  PWM lines, asynchronous. Bit 0 = R, 1 = G, 2 = B.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_chan`  out  2  channel of the result, 0..2.
- `res_high`  out  CNT_W  high cycles within the period.
- `res_period`  out  CNT_W  cycles from one rising edge to the next.
- `res_stuck`  out  1  timeout result, where `res_high` is 0 or TIMEOUT.
- `overrun`  out  3  sticky per channel: an undelivered result was overwritten.
- `clr_overrun`  in  1  synchronous clear of `overrun`.

## Operation
- Input conditioning, per channel:
  - 2-flop synchronizer, then a registered previous-level copy for edge detect.
  - Rise = sync & ~prev; fall = ~sync & prev.
- Channel FSM states:
  - IDLE → HIGH on rise. Sets `hcnt` = 1 and `pcnt` = 1.
  - HIGH: `hcnt`++ and `pcnt`++ each cycle. On fall → LOW, freezing `hcnt`.
  - LOW: `pcnt`++ each cycle. On rise → emit {high=`hcnt`, period=`pcnt`, stuck=0} and return to HIGH with both counts reset to 1.
  - Any state except IDLE: `pcnt` == TIMEOUT with no rise in that cycle → emit {high = (state==HIGH ? TIMEOUT : 0), period=TIMEOUT, stuck=1} → IDLE.
  - IDLE emits nothing. A static line produces exactly one stuck result, and only after at least one rise.
- Counters never exceed TIMEOUT, so there is no wrap.
- A glitch shorter than one clock can be missed entirely; that is accepted.
- Result slot, one entry per channel:
  - An emit fills the slot.
  - An emit into a full slot that is not being drained in the same cycle overwrites it with the newer result and sets `overrun[ch]`.
  - An emit in the same cycle as that slot's drain is not an overrun.
- Output arbitration:
  - The output register loads when it is empty, or when `res_valid & res_ready` this cycle.
  - Source is the next pending slot round-robin, starting after the last granted channel. Reset pointer = 2, so channel 0 has first priority.
  - Output fields are held stable while `res_valid & ~res_ready`.
- `clr_overrun` and a new overrun in the same cycle: the set wins.
- `enable` low:
  - Channel FSMs go to IDLE and counts clear.
  - Pending slots and the output register still drain.
  - Synchronizers keep running.
- Reset values:
  - All FSMs IDLE, counts 0, slots empty.
  - `res_valid` 0, `res_chan` 0, `res_high` 0, `res_period` 0, `res_stuck` 0, `overrun` 0.
  - Synchronizer flops 0.

## Timing
- `rgb_in` change sampled at edge k is seen by the FSM at edge k+2 (synchronized) and detected at edge k+3.
- The emit registers into the slot at k+3. The earliest `res_valid` is at k+4.
- Throughput: one result per cycle on the output port. Each channel can emit at most once every 2 cycles.
- Period and high measure with ±1-cycle quantization relative to the pin; the pipeline delay is equal for rise and fall.
- Reset mid-operation clears everything asynchronously. The first result after reset release needs two rises.

## Structure
- Package `rgb_pwm_pkg` holds:
  - Channel FSM state enum (IDLE, HIGH, LOW).
  - Channel index constants (CH_R=0, CH_G=1, CH_B=2).
  - Default CNT_W.
- Sub-module `rgb_pwm_chan` holds synchronizer, edge detect, FSM, counters and the emit signals. It is instantiated 3×.
- The top level holds slots, round-robin arbiter, output register and overrun logic.

## Test plan
- R: PWM high 3 / period 10 repeating, `res_ready`=1 → results chan 0, high 3, period 10, stuck 0 from the second rise on. The first `res_valid` comes 4 cycles after the second rise sampled.
- G held high after one rise, TIMEOUT=16 → exactly one result: chan 1, high 16, period 16, stuck 1. Then silence.
- All three channels rise in the same cycle with identical PWM, `res_ready`=1 → results in order 0, 1, 2 on consecutive cycles.
- `res_ready`=0 while B produces two results → the output holds the first result stable, the slot holds the second, and `overrun`=3'b000. A third B result sets `overrun`=3'b100. `clr_overrun` clears it.
- `enable` dropped mid-HIGH on R with a pending result → the pending result is still delivered. No further results until `enable` returns and two rises occur.
- Assert `rst` mid-period with `res_valid`=1 → `res_valid`=0 immediately (asynchronous). All outputs and `overrun` are 0.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM capture block.
// Latency: n/a (package).
// Backpressure: n/a (package).
package rgb_pwm_pkg;

    localparam int CNT_W_DEF = 20;
    localparam int NUM_CH    = 3;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } chan_state_e;

    // Round-robin pick over three pending flags, starting after 'last'.
    // Returns {found, channel}.
    function automatic logic [2:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
        logic [1:0] c0, c1, c2;
        case (last)
            CH_R:    begin c0 = CH_G; c1 = CH_B; c2 = CH_R; end
            CH_G:    begin c0 = CH_B; c1 = CH_R; c2 = CH_G; end
            default: begin c0 = CH_R; c1 = CH_G; c2 = CH_B; end
        endcase
        if (pend[c0])      return {1'b1, c0};
        else if (pend[c1]) return {1'b1, c1};
        else if (pend[c2]) return {1'b1, c2};
        else               return 3'b000;
    endfunction

endpackage

// File: rtl/rgb_pwm_capture_if.sv
// Result port of the PWM capture block: one measurement per transfer.
// Latency: n/a (interface).
// Backpressure: valid/ready; master holds all fields while valid & ~ready.
// Ports: res_valid/res_chan/res_high/res_period/res_stuck from master, res_ready from slave.
interface rgb_pwm_capture_if #(
    parameter int CNT_W = rgb_pwm_pkg::CNT_W_DEF
);
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_chan;
    logic [CNT_W-1:0] res_high;
    logic [CNT_W-1:0] res_period;
    logic             res_stuck;

    modport master (
        output res_valid, res_chan, res_high, res_period, res_stuck,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_chan, res_high, res_period, res_stuck,
        output res_ready
    );
endinterface

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: synchronizer, edge detect, IDLE/HIGH/LOW FSM, high/period counters.
// Latency: pin change at edge k -> FSM acts and emits at edge k+3.
// Backpressure: none; emit is a one-cycle pulse the parent must capture.
// Ports: clk, rst (async active-low), enable, pin; emit, emit_high, emit_period, emit_stuck.
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
#(
    parameter int          CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = 32'h000F_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pin,
    output logic             emit,
    output logic [CNT_W-1:0] emit_high,
    output logic [CNT_W-1:0] emit_period,
    output logic             emit_stuck
);

    localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic        sync1_q, sync2_q, prev_q;
    logic        rise_q, fall_q;
    chan_state_e state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d;

    // Edge pulses are registered, so rise and fall see the same pipeline delay
    // and the FSM works from flop outputs only. Runs regardless of enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
            fall_q  <= ~sync2_q & prev_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        pcnt_d      = pcnt_q;
        emit        = 1'b0;
        emit_high   = '0;
        emit_period = '0;
        emit_stuck  = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
            pcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_q) begin
                        state_d = ST_HIGH;
                        hcnt_d  = ONE;
                        pcnt_d  = ONE;
                    end
                end
                ST_HIGH: begin
                    // A rise cannot arrive in HIGH (a fall must come first),
                    // so reaching TO here always means the line stuck high.
                    if (pcnt_q == TO) begin
                        emit        = 1'b1;
                        emit_high   = TO;
                        emit_period = TO;
                        emit_stuck  = 1'b1;
                        state_d     = ST_IDLE;
                        hcnt_d      = '0;
                        pcnt_d      = '0;
                    end else if (fall_q) begin
                        state_d = ST_LOW;
                        pcnt_d  = pcnt_q + ONE;
                    end else begin
                        hcnt_d  = hcnt_q + ONE;
                        pcnt_d  = pcnt_q + ONE;
                    end
                end
                ST_LOW: begin
                    // A rise wins over the timeout when both land together.
                    if (rise_q) begin
                        emit        = 1'b1;
                        emit_high   = hcnt_q;
                        emit_period = pcnt_q;
                        state_d     = ST_HIGH;
                        hcnt_d      = ONE;
                        pcnt_d      = ONE;
                    end else if (pcnt_q == TO) begin
                        emit        = 1'b1;
                        emit_period = TO;
                        emit_stuck  = 1'b1;
                        state_d     = ST_IDLE;
                        hcnt_d      = '0;
                        pcnt_d      = '0;
                    end else begin
                        pcnt_d  = pcnt_q + ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hcnt_d  = '0;
                    pcnt_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rgb_pwm_capture.sv
// Three-channel RGB PWM capture: per-channel result slots, round-robin onto one result port.
// Latency: pin change at edge k -> slot at k+3 -> res_valid at k+4; one result per cycle.
// Backpressure: valid/ready; a full undrained slot is overwritten and flags sticky overrun.
// Ports: clk, rst (async active-low), enable, rgb_in[2:0], clr_overrun, overrun[2:0], res (master).
module rgb_pwm_capture
    import rgb_pwm_pkg::*;
#(
    parameter int          CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = 32'h000F_FFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         rgb_in,
    input  logic                      clr_overrun,
    output logic [NUM_CH-1:0]         overrun,
    rgb_pwm_capture_if.master         res
);

    typedef struct packed {
        logic             stuck;
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] period;
    } res_t;

    logic [NUM_CH-1:0] e_vld;
    logic [NUM_CH-1:0] e_stuck;
    logic [CNT_W-1:0]  e_high   [NUM_CH];
    logic [CNT_W-1:0]  e_period [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        rgb_pwm_chan #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable),
            .pin         (rgb_in[g]),
            .emit        (e_vld[g]),
            .emit_high   (e_high[g]),
            .emit_period (e_period[g]),
            .emit_stuck  (e_stuck[g])
        );
    end

    res_t              slot_q [NUM_CH];
    logic [NUM_CH-1:0] slot_vld_q;
    logic [NUM_CH-1:0] overrun_q;

    logic       out_vld_q;
    logic [1:0] out_chan_q;
    res_t       out_q;
    logic [1:0] last_q;

    logic              load;
    logic [2:0]        pick;
    logic              pick_vld;
    logic [1:0]        pick_ch;
    logic [NUM_CH-1:0] drain;
    logic [NUM_CH-1:0] ovr_set;

    assign load     = ~out_vld_q | res.res_ready;
    assign pick     = rr_pick(slot_vld_q, last_q);
    assign pick_vld = pick[2];
    assign pick_ch  = pick[1:0];

    // A slot drained in the same cycle it is refilled has not lost anything.
    always_comb begin
        drain   = '0;
        ovr_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            drain[i]   = load & pick_vld & (pick_ch == 2'(i));
            ovr_set[i] = e_vld[i] & slot_vld_q[i] & ~drain[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_vld_q <= '0;
            for (int i = 0; i < NUM_CH; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (e_vld[i]) begin
                    slot_q[i]     <= '{stuck: e_stuck[i], high: e_high[i], period: e_period[i]};
                    slot_vld_q[i] <= 1'b1;
                end else if (drain[i]) begin
                    slot_vld_q[i] <= 1'b0;
                end
            end
        end
    end

    // Pointer resets to B so that R has first priority after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld_q  <= 1'b0;
            out_chan_q <= '0;
            out_q      <= '0;
            last_q     <= CH_B;
        end else if (load) begin
            out_vld_q <= pick_vld;
            if (pick_vld) begin
                out_q      <= slot_q[pick_ch];
                out_chan_q <= pick_ch;
                last_q     <= pick_ch;
            end
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overrun_q <= '0;
        else      overrun_q <= (clr_overrun ? '0 : overrun_q) | ovr_set;
    end

    assign overrun        = overrun_q;
    assign res.res_valid  = out_vld_q;
    assign res.res_chan   = out_chan_q;
    assign res.res_high   = out_q.high;
    assign res.res_period = out_q.period;
    assign res.res_stuck  = out_q.stuck;

endmodule
